// File: rtl/multi32_stream_ctrl.sv
// Valid/ready wrapper around a free-running pipelined multiplier: issues operand
// pairs, captures products after MUL_LAT clocks and buffers them in a result FIFO.
module multi32_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic [DATA_WIDTH-1:0]   mul_dat1,
  output logic [DATA_WIDTH-1:0]   mul_dat2,
  input  logic [2*DATA_WIDTH-1:0] mul_product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_product,
  output logic                    busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = $clog2(FIFO_DEPTH + MUL_LAT + 1);

  generate
    if (MUL_LAT < 1 || FIFO_DEPTH < MUL_LAT + 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("multi32_stream_ctrl: FIFO_DEPTH must be a power of 2 and >= MUL_LAT+2");
    end
  endgenerate

  logic [MUL_LAT-1:0]      vld_sr;
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic [AW:0]             count;
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] last_head;
  logic [SW-1:0]           credit_used;
  logic                    issue;
  logic                    capture;
  logic                    pop;
  logic                    empty;
  logic                    full;

  // Buffered plus in-flight products; a same-cycle pop is deliberately not
  // credited so out_ready has no combinational path to in_ready.
  always_comb begin
    credit_used = SW'(count);
    for (int unsigned i = 0; i < MUL_LAT; i++) begin
      credit_used = credit_used + SW'(vld_sr[i]);
    end
  end

  assign in_ready = !rst && (credit_used < SW'(FIFO_DEPTH));
  assign issue    = in_valid & in_ready;
  assign mul_dat1 = issue ? in_a : '0;
  assign mul_dat2 = issue ? in_b : '0;

  assign capture  = vld_sr[MUL_LAT-1];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = out_ready & ~empty;

  assign out_valid = ~empty;
  // When empty the last popped head is presented so the bus does not wander.
  assign out_product = empty ? last_head : mem[rd_ptr[AW-1:0]];
  assign busy        = (|vld_sr) | ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_head <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr[AW-1:0]] <= mul_product;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(capture && full))
    else $error("multi32_stream_ctrl: capture into full FIFO");

endmodule

// File: tb/tb_multi32_stream_ctrl.sv
// Directed bench for multi32_stream_ctrl with a 2-stage multiplier model on the side.
module tb_multi32_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] mul_dat1;
  logic [31:0] mul_dat2;
  logic [63:0] mul_product;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_product;
  logic        busy;

  logic [63:0] mp1 = '0;
  logic [63:0] mp2 = '0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  multi32_stream_ctrl #(
    .DATA_WIDTH(32),
    .MUL_LAT(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .mul_dat1(mul_dat1),
    .mul_dat2(mul_dat2),
    .mul_product(mul_product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_product(out_product),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running multiplier: operands sampled at edge, product visible two clocks later.
  always @(posedge clk) begin
    mp1 <= {32'd0, mul_dat1} * {32'd0, mul_dat2};
    mp2 <= mp1;
  end
  assign mul_product = mp2;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9; out_ready = 1'b1;
    #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (out_product !== 64'd0) begin n_err++; $display("FAIL reset_out_product: got %h want 0", out_product); end
      next_cycle();
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL post_reset_idle: out_valid=%b busy=%b want 0 0", out_valid, busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_single(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (mul_dat1 !== a || mul_dat2 !== b) begin
      n_err++; $display("FAIL single_mul_dat: got %h %h want %h %h", mul_dat1, mul_dat2, a, b);
    end
    next_cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (mul_dat1 !== 32'd0 || mul_dat2 !== 32'd0) begin
          n_err++; $display("FAIL single_mul_idle: got %h %h want 0 0", mul_dat1, mul_dat2);
        end
      end
      if (c < 3) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid c%0d: got %b want 0", c, out_valid); end
      end else if (c == 3) begin
        n_cmp++; if (out_valid !== 1'b1 || out_product !== exp) begin
          n_err++; $display("FAIL single_result: valid=%b product=%h want 1 %h", out_valid, out_product, exp);
        end
      end else begin
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
          n_err++; $display("FAIL single_idle_after: busy=%b valid=%b want 0 0", busy, out_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stream;
    logic [63:0] exp;
    out_ready = 1'b1; in_b = 32'hFFFF_FFFF;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin in_valid = 1'b1; in_a = 32'(c + 1); end
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 8) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      if (c >= 3 && c < 11) begin
        exp = 64'(c - 2) * 64'h0000_0000_FFFF_FFFF;
        n_cmp++; if (out_valid !== 1'b1 || out_product !== exp) begin
          n_err++; $display("FAIL stream_out c%0d: valid=%b product=%h want 1 %h", c, out_valid, out_product, exp);
        end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_gap c%0d: got %b want 0", c, out_valid); end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] exp_q[$];
    logic [63:0] exp;
    int unsigned acc;
    int unsigned idx;
    int unsigned popped;
    logic issued;
    acc = 0; idx = 0; popped = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'd10; in_b = 32'd20;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      issued = in_ready;
      if (issued) begin exp_q.push_back(64'(in_a) * 64'(in_b)); acc++; end
      if (c >= 4) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready c%0d: got %b want 0", c, in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_product !== 64'd200) begin
          n_err++; $display("FAIL bp_hold c%0d: valid=%b product=%h want 1 c8", c, out_valid, out_product);
        end
      end
      next_cycle();
      if (issued) begin idx++; in_a = 32'(10 + idx); in_b = 32'(20 + idx); end
    end
    n_cmp++; if (acc != 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    out_ready = 1'b1;
    for (int d = 0; d < 40; d++) begin
      @(negedge clk);
      if (d == 0) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_pop_credit: got %b want 0", in_ready); end
      end
      if (d == 1) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume: got %b want 1", in_ready); end
      end
      issued = in_valid & in_ready;
      if (issued) exp_q.push_back(64'(in_a) * 64'(in_b));
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_drain_extra: got %h want none", out_product);
        end else begin
          exp = exp_q.pop_front();
          popped++;
          if (out_product !== exp) begin n_err++; $display("FAIL bp_drain_order #%0d: got %h want %h", popped, out_product, exp); end
        end
      end
      next_cycle();
      if (issued) begin
        idx++; in_a = 32'(10 + idx); in_b = 32'(20 + idx);
        if (idx >= 8) in_valid = 1'b0;
      end
      if (exp_q.size() == 0 && !in_valid) break;
    end
    n_cmp++; if (popped != 8) begin n_err++; $display("FAIL bp_drain_count: got %0d want 8", popped); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_final_idle: busy=%b valid=%b want 0 0", busy, out_valid);
    end
    next_cycle();
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b1; in_valid = 1'b1; in_a = 32'd4; in_b = 32'd5;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_first_issue: got %b want 1", in_ready); end
    next_cycle();
    rst = 1'b1; in_a = 32'd8; in_b = 32'd9;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mr_during_reset: in_ready=%b busy=%b want 0 0", in_ready, busy);
    end
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_ghost c%0d: got %b want 0", c, out_valid); end
      next_cycle();
    end
    in_valid = 1'b1; in_a = 32'd7; in_b = 32'd6;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_reissue_ready: got %b want 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c < 3) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_early c%0d: got %b want 0", c, out_valid); end
      end else begin
        n_cmp++; if (out_valid !== 1'b1 || out_product !== 64'd42) begin
          n_err++; $display("FAIL mr_result: valid=%b product=%0d want 1 42", out_valid, out_product);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single(32'd3, 32'd5, 64'd15);
    test_stream();
    test_backpressure();
    test_single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
